// File: rtl/md_unit.sv
// Iterative multiply/divide unit for the EX stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Optional macro MD_DIV_ZERO_EARLY_EN: a divide by zero skips the iteration phase and finishes in one cycle.
module md_unit #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_ITER   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        isbusy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MLEN  = XLEN + 1;
  localparam int unsigned PLEN  = 2 * XLEN;
  localparam int unsigned CNT_W = 6;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MLEN-1:0]   ma_q, ma_d;
  logic [MLEN-1:0]   mb_q, mb_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;

  logic [PLEN-1:0]   prod;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic              sgn_a;
  logic              sgn_b;

  // Two's-complement product of the 33-bit extended operands, kept modulo 2^64.
  always_comb begin
    prod = {{(PLEN-MLEN){ma_q[MLEN-1]}}, ma_q} * {{(PLEN-MLEN){mb_q[MLEN-1]}}, mb_q};
  end

  // One restoring-division step: shift {rem,quot} left, trial-subtract the divisor.
  always_comb begin
    rem_sh = {rem_q, quot_q[XLEN-1]};
    div_ge = (rem_sh >= {1'b0, dvs_q});
  end

  always_comb begin
    sgn_a = (md_op == OP_DIV) && src_a[XLEN-1];
    sgn_b = (md_op == OP_DIV) && src_b[XLEN-1];
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            OP_MULT, OP_MULTU: begin
              ma_d    = {(md_op == OP_MULT) && src_a[XLEN-1], src_a};
              mb_d    = {(md_op == OP_MULT) && src_b[XLEN-1], src_b};
              cnt_d   = CNT_W'(MUL_CYCLES - 1);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              quot_d  = sgn_a ? (XLEN'(0) - src_a) : src_a;
              dvs_d   = sgn_b ? (XLEN'(0) - src_b) : src_b;
              rem_d   = '0;
              negq_d  = sgn_a ^ sgn_b;
              negr_d  = sgn_a;
              cnt_d   = CNT_W'(DIV_ITER - 1);
              state_d = S_DIV;
`ifdef MD_DIV_ZERO_EARLY_EN
              // Preload the final divide-by-zero result so FIX copies it unchanged.
              if (src_b == '0) begin
                quot_d  = '1;
                rem_d   = src_a;
                negq_d  = 1'b0;
                negr_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_FIX;
              end
`else
`endif
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = prod[PLEN-1:XLEN];
          lo_d    = prod[XLEN-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DIV: begin
        rem_d  = div_ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], div_ge};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_FIX: begin
        lo_d    = negq_q ? (XLEN'(0) - quot_q) : quot_q;
        hi_d    = negr_q ? (XLEN'(0) - rem_q) : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Flush cancels everything, including a same-cycle start or completing write.
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign isbusy = busy_q;
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: scoreboard of expected HI/LO, busy-length, done-pulse and flush/reset checks.
module tb_md_unit;

  localparam int unsigned MUL_CYCLES = 2;
  localparam int unsigned DIV_ITER   = 32;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        isbusy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  res_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  md_unit #(.MUL_CYCLES(MUL_CYCLES), .DIV_ITER(DIV_ITER)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .md_op  (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .isbusy (isbusy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference results computed from native integer arithmetic.
  function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint p;
    int     sa;
    int     sb;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        r = res_t'(p);
      end
      OP_MULTU: begin
        p = longint'({32'd0, a}) * longint'({32'd0, b});
        r = res_t'(p);
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          r.hi = a;
`ifdef MD_DIV_ZERO_EARLY_EN
          r.lo = 32'hFFFF_FFFF;
`else
          r.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
`endif
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.hi = 32'd0;
          r.lo = 32'h8000_0000;
        end else begin
          r.lo = sa / sb;
          r.hi = sa % sb;
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          r.hi = a;
          r.lo = 32'hFFFF_FFFF;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
    if (op == OP_MULT || op == OP_MULTU) return int'(MUL_CYCLES);
`ifdef MD_DIV_ZERO_EARLY_EN
    if (b == 32'd0) return 1;
`else
    if (b == 32'd0) return int'(DIV_ITER) + 1;
`endif
    return int'(DIV_ITER) + 1;
  endfunction

  // Issue one MULT/DIV op and check busy length, done pulse and HI/LO from the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t e;
    int   n;
    int   early;
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    n = 0;
    early = 0;
    while (isbusy && n < 100) begin
      n++;
      if (done) early++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'(exp_busy(op, b)));
    chk({tag, " done_while_busy"}, 64'(early), 64'd0);
    chk({tag, " done_pulse"}, 64'(done), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, " hi"}, 64'(hi), 64'(e.hi));
      chk({tag, " lo"}, 64'(lo), 64'(e.lo));
    end
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    int          n;
    int          dones;

    rst = 1'b1; start = 1'b0; md_op = OP_NONE; src_a = '0; src_b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset isbusy", 64'(isbusy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    rst = 1'b0;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max hi const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_max lo const", 64'(lo), 64'h0000_0000_0000_0001);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE);
    chk("div_7_m2 lo const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    chk("divu_100_7 lo const", 64'(lo), 64'd14);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_neg_rem", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0);

    for (int i = 0; i < 6; i++) begin
      rop = 3'(int'(OP_MULT) + $urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    // MTHI then MTLO on back-to-back edges.
    @(negedge clk);
    start = 1'b1; md_op = OP_MTHI; src_a = 32'h1234_5678;
    @(negedge clk);
    chk("mthi hi", 64'(hi), 64'h1234_5678);
    chk("mthi isbusy", 64'(isbusy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    md_op = OP_MTLO; src_a = 32'hCAFE_BABE;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    chk("mtlo lo", 64'(lo), 64'hCAFE_BABE);
    chk("mtlo hi kept", 64'(hi), 64'h1234_5678);
    chk("mtlo isbusy", 64'(isbusy), 64'd0);
    chk("mtlo done", 64'(done), 64'd0);

    // Flush at busy cycle 10 of DIV 50/5, with an ignored second start at cycle 3.
    move(OP_MTHI, 32'hAAAA_0000);
    move(OP_MTLO, 32'h0000_BBBB);
    @(negedge clk);
    start = 1'b1; md_op = OP_DIV; src_a = 32'd50; src_b = 32'd5;
    @(negedge clk);
    n = 0;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      if (isbusy) n++;
      if (done) dones++;
      start = (c == 3);
      md_op = (c == 3) ? OP_MULTU : OP_NONE;
      flush = (c == 10);
      @(negedge clk);
    end
    start = 1'b0; md_op = OP_NONE; flush = 1'b0;
    chk("flush busy_before", 64'(n), 64'd10);
    chk("flush isbusy", 64'(isbusy), 64'd0);
    chk("flush done", 64'(done + 1'(dones)), 64'd0);
    chk("flush hi", 64'(hi), 64'hAAAA_0000);
    chk("flush lo", 64'(lo), 64'h0000_BBBB);
    dones = 0;
    repeat (40) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("flush no_late_done", 64'(dones), 64'd0);

    // Flush on the completing MUL edge suppresses the write.
    @(negedge clk);
    start = 1'b1; md_op = OP_MULT; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_mul isbusy", 64'(isbusy), 64'd0);
    chk("flush_mul done", 64'(done), 64'd0);
    chk("flush_mul hi", 64'(hi), 64'hAAAA_0000);
    chk("flush_mul lo", 64'(lo), 64'h0000_BBBB);

    // Flush beats a same-cycle MTHI.
    @(negedge clk);
    start = 1'b1; md_op = OP_MTHI; src_a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE; flush = 1'b0;
    chk("flush_mthi hi", 64'(hi), 64'hAAAA_0000);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; md_op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    repeat (5) @(negedge clk);
    chk("rst_mid isbusy_before", 64'(isbusy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid isbusy", 64'(isbusy), 64'd0);
    chk("rst_mid done", 64'(done), 64'd0);
    chk("rst_mid hi", 64'(hi), 64'd0);
    chk("rst_mid lo", 64'(lo), 64'd0);

    run_op("after_rst_mult", OP_MULT, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
    chk("scoreboard empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
